spi_rx_mode: RTL and testbench
==============================

Name: spi_rx_mode

Overview:
Parametrised SPI slave-side receiver supporting all four CPOL/CPHA modes, chip-select framing, MSB- or LSB-first order and a run-time frame length of 1..SPI_RX_WIDTH bits. Oversamples the SPI bus with the system clock and presents each received word on a one-entry valid/ready output buffer, with a sticky overrun flag. Sits between the SPI pad interface and register/FIFO logic in the peripheral subsystem.

Parameters:
DLY, 1, simulation delay on sequential assignments
SPI_RX_WIDTH, 32, maximum frame width in bits (>=2)
LENGTH_RECEIVE, $clog2(SPI_RX_WIDTH+1), width of length and bit counter
SYNC_STAGES, 2, synchroniser depth for spi_bus_clk, spi_cs_n and sdi (>=2)

Ports:
clk  input  1  primary clock; the only clock
rst  input  1  asynchronous, active-high reset
cpol  input  1  clock polarity, captured at frame start
cpha  input  1  clock phase, captured at frame start
msb_first  input  1  1: first bit is MSB of word; captured at frame start
length  input  LENGTH_RECEIVE  bits per word; 0 or >SPI_RX_WIDTH treated as SPI_RX_WIDTH; captured at frame start
spi_bus_clk  input  1  SPI SCLK, asynchronous
spi_cs_n  input  1  SPI chip select, active low, asynchronous
sdi  input  1  SPI MOSI, asynchronous
rx_rdata  output  SPI_RX_WIDTH  received word, right-justified, unused upper bits 0
rx_vld  output  1  rx_rdata valid; held until accepted
rx_rdy  input  1  downstream accepts when rx_vld && rx_rdy
rx_overrun  output  1  sticky: word completed while buffer full
overrun_clr  input  1  clears rx_overrun
rx_interrupt  output  1  one-clk pulse when a word is loaded into the buffer
rx_abort  output  1  one-clk pulse when cs_n rises with a partial word
rx_busy  output  1  high while state is RECV

Behaviour:
- Reset (rst high, async): state IDLE, bit counter 0, shift reg 0, rx_rdata 0, rx_vld 0, rx_overrun 0, rx_interrupt 0, rx_abort 0, rx_busy 0, synchroniser flops 0 except cs_n stages 1.
- All three bus inputs pass through SYNC_STAGES flops; edges detected by comparing sync output with one extra registered copy.
- Sample edge: rising SCLK when cpol==cpha (modes 0,3), falling SCLK otherwise (modes 1,2). Other edge ignored.
- FSM IDLE: on synced cs_n falling edge, capture cpol/cpha/msb_first/clamped length, clear counter and shift reg, go RECV.
- FSM RECV: on each sample edge, store synced sdi, counter+1. MSB-first: shift left, sdi into bit 0. LSB-first: sdi written to bit[counter]. When counter reaches length-1 on a sample edge the word is complete: counter and shift reg clear, remain in RECV (back-to-back words while cs_n low).
- Synced cs_n rising in RECV: go IDLE; if counter!=0 pulse rx_abort next cycle, partial word discarded, buffer untouched.
- Config inputs changing mid-frame have no effect until next cs_n fall.
- Word completion: on the clk edge after the completing sample edge, if buffer empty or (rx_vld && rx_rdy) same cycle: load rx_rdata, rx_vld=1, rx_interrupt pulse 1 cycle. Else: word dropped, old rx_rdata kept, rx_overrun set.
- rx_vld && rx_rdy without completion: rx_vld clears next cycle, rx_rdata holds.
- overrun_clr and a new overrun in same cycle: rx_overrun stays 1.
- Latency: raw sampling edge to rx_vld = SYNC_STAGES+2 clk cycles.
- SCLK frequency must be <= clk/4; slower edges are required for correct detection.
- Sample edge and cs_n rise in same cycle: sample taken first, completion honoured, then IDLE.

Decomposition:
- Package spi_pkg: FSM state localparams (IDLE, RECV), mode encodings MODE0..MODE3, function for sample-edge select and length clamp.
- Sub-module spi_sync: SYNC_STAGES-deep synchroniser with reset value parameter, instanced per bus input.

Test Plan:
- Mode 0, msb_first=1, length=8, send 0xA5, rx_rdy=1 -> rx_rdata=0x000000A5, rx_vld and rx_interrupt one cycle each, rx_overrun=0.
- Mode 3 and mode 1, lsb_first, length=32, send 0x12345678 -> rx_rdata=0x12345678 in both modes.
- cs_n held low, three 8-bit words 0x11,0x22,0x33, rx_rdy=0 -> rx_rdata=0x11, rx_overrun=1, no further rx_interrupt; overrun_clr -> 0.
- length=0 sampled at frame start then length changed to 4 mid-frame -> 32-bit word received, rx_vld after bit 32.
- cs_n raised after 5 of 8 bits -> rx_abort pulse, rx_vld stays 0, next full frame 0x3C received correctly.
- rst asserted mid-frame after 3 bits -> all outputs 0 immediately; subsequent frame 0xFF received as 0x000000FF.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave receiver: FSM states, SPI mode
// encodings, sample-edge selection and frame-length clamping.
package spi_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    // Mode number is {cpol, cpha}
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    function automatic logic sample_on_rise(input spi_mode_e mode);
        return (mode == MODE0) || (mode == MODE3);
    endfunction

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_w);
        return ((len == 0) || (len > max_w)) ? max_w : len;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous bus input, with a selectable
// reset level so idle-high lines do not produce a false edge out of reset.
module spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_rx_mode.sv
// SPI slave receiver: oversamples SCLK/CS_N/SDI, assembles frames of 1..SPI_RX_WIDTH
// bits in any CPOL/CPHA mode and hands words to a one-entry valid/ready buffer.
module spi_rx_mode
    import spi_pkg::*;
#(
    parameter int          DLY            = 1,
    parameter int unsigned SPI_RX_WIDTH   = 32,
    parameter int unsigned LENGTH_RECEIVE = $clog2(SPI_RX_WIDTH + 1),
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpol,
    input  logic                      cpha,
    input  logic                      msb_first,
    input  logic [LENGTH_RECEIVE-1:0] length,
    input  logic                      spi_bus_clk,
    input  logic                      spi_cs_n,
    input  logic                      sdi,
    output logic [SPI_RX_WIDTH-1:0]   rx_rdata,
    output logic                      rx_vld,
    input  logic                      rx_rdy,
    output logic                      rx_overrun,
    input  logic                      overrun_clr,
    output logic                      rx_interrupt,
    output logic                      rx_abort,
    output logic                      rx_busy
);

    if (DLY < 0 || SPI_RX_WIDTH < 2 || SYNC_STAGES < 2) begin : g_param_check
        $error("spi_rx_mode: illegal parameter value");
    end

    logic sclk_s, cs_s, sdi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(spi_bus_clk), .q_o(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d_i(spi_cs_n), .q_o(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst(rst), .d_i(sdi), .q_o(sdi_s)
    );

    logic                      sclk_q, cs_q;
    state_e                    state_q, state_d;
    spi_mode_e                 mode_q, mode_d;
    logic                      msb_q, msb_d;
    logic [LENGTH_RECEIVE-1:0] len_q, len_d;
    logic [LENGTH_RECEIVE-1:0] cnt_q, cnt_d;
    logic [SPI_RX_WIDTH-1:0]   shift_q, shift_d;
    logic [SPI_RX_WIDTH-1:0]   word_q, word_d;
    logic                      done_q, done_d;
    logic                      abort_q, abort_d;
    logic [SPI_RX_WIDTH-1:0]   rdata_q, rdata_d;
    logic                      vld_q, vld_d;
    logic                      int_q, int_d;
    logic                      ovr_q, ovr_d;

    logic                      sclk_rise, sclk_fall, cs_fall, cs_rise, sample;
    logic [SPI_RX_WIDTH-1:0]   shift_cat;

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_fall   = ~cs_s & cs_q;
    assign cs_rise   = cs_s & ~cs_q;
    assign sample    = sample_on_rise(mode_q) ? sclk_rise : sclk_fall;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        msb_d     = msb_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        word_d    = word_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        shift_cat = msb_q ? {shift_q[SPI_RX_WIDTH-2:0], sdi_s}
                          : (shift_q | (SPI_RX_WIDTH'(sdi_s) << cnt_q));
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    mode_d  = spi_mode_e'({cpol, cpha});
                    msb_d   = msb_first;
                    len_d   = LENGTH_RECEIVE'(clamp_len(32'(length), SPI_RX_WIDTH));
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (sample) begin
                    if (cnt_q == len_q - LENGTH_RECEIVE'(1)) begin
                        word_d  = shift_cat;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        shift_d = '0;
                    end else begin
                        cnt_d   = cnt_q + LENGTH_RECEIVE'(1);
                        shift_d = shift_cat;
                    end
                end
                // Abort decision uses the post-sample count so a word completing on
                // the same cycle as cs_n rising is delivered, not aborted.
                if (cs_rise) begin
                    state_d = IDLE;
                    abort_d = (cnt_d != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        vld_d   = vld_q;
        int_d   = 1'b0;
        ovr_d   = ovr_q & ~overrun_clr;
        if (done_q) begin
            if (!vld_q || rx_rdy) begin
                rdata_d = word_q;
                vld_d   = 1'b1;
                int_d   = 1'b1;
            end else begin
                ovr_d   = 1'b1;
            end
        end else if (vld_q && rx_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            state_q <= IDLE;
            mode_q  <= MODE0;
            msb_q   <= 1'b1;
            len_q   <= LENGTH_RECEIVE'(SPI_RX_WIDTH);
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            rdata_q <= '0;
            vld_q   <= 1'b0;
            int_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sclk_q  <= sclk_s;
            cs_q    <= cs_s;
            state_q <= state_d;
            mode_q  <= mode_d;
            msb_q   <= msb_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            rdata_q <= rdata_d;
            vld_q   <= vld_d;
            int_q   <= int_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_rdata     = rdata_q;
    assign rx_vld       = vld_q;
    assign rx_interrupt = int_q;
    assign rx_overrun   = ovr_q;
    assign rx_abort     = abort_q;
    assign rx_busy      = (state_q == RECV);

endmodule

// File: tb/tb_spi_rx_mode.sv
// Directed bench for spi_rx_mode: drives SPI frames in all modes and checks
// received words, handshake pulses, overrun, abort, length capture and reset.
module tb_spi_rx_mode;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpol, cpha, msb_first;
    logic [5:0]  length;
    logic        spi_bus_clk, spi_cs_n, sdi;
    logic [31:0] rx_rdata;
    logic        rx_vld, rx_rdy, rx_overrun, overrun_clr;
    logic        rx_interrupt, rx_abort, rx_busy;

    int  checks = 0;
    int  errors = 0;
    int  int_cnt = 0;
    int  abort_cnt = 0;
    int  vld_cnt = 0;
    time vld_rise_t = 0;
    time sample_t = 0;
    logic prev_vld = 1'b0;
    logic cur_cpha = 1'b0;

    spi_rx_mode dut (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .msb_first(msb_first),
        .length(length), .spi_bus_clk(spi_bus_clk), .spi_cs_n(spi_cs_n), .sdi(sdi),
        .rx_rdata(rx_rdata), .rx_vld(rx_vld), .rx_rdy(rx_rdy), .rx_overrun(rx_overrun),
        .overrun_clr(overrun_clr), .rx_interrupt(rx_interrupt), .rx_abort(rx_abort),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_interrupt) int_cnt++;
        if (rx_abort) abort_cnt++;
        if (rx_vld) vld_cnt++;
        if (rx_vld && !prev_vld) vld_rise_t = $time;
        prev_vld = rx_vld;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low(input logic pol, input logic pha, input logic msb, input logic [5:0] len);
        cpol = pol; cpha = pha; msb_first = msb; length = len;
        cur_cpha = pha; spi_bus_clk = pol; sdi = 1'b0;
        wait_clks(6);
        spi_cs_n = 1'b0;
        wait_clks(6);
    endtask

    task automatic send_bits(input logic [31:0] data, input int n, input logic msb);
        for (int i = 0; i < n; i++) begin
            wait_clks(2);
            sdi = msb ? data[n-1-i] : data[i];
            wait_clks(2);
            spi_bus_clk = ~spi_bus_clk;
            if (!cur_cpha) sample_t = $time;
            wait_clks(4);
            spi_bus_clk = ~spi_bus_clk;
            if (cur_cpha) sample_t = $time;
        end
    endtask

    task automatic cs_high;
        wait_clks(4);
        spi_cs_n = 1'b1;
        wait_clks(10);
    endtask

    task automatic test_reset;
        rst = 1'b1; cpol = 0; cpha = 0; msb_first = 1; length = 6'd8;
        spi_bus_clk = 0; spi_cs_n = 1; sdi = 0; rx_rdy = 0; overrun_clr = 0;
        wait_clks(3);
        checks++;
        if ({rx_rdata, rx_vld, rx_overrun, rx_interrupt, rx_abort, rx_busy} !== 37'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0",
                     {rx_rdata, rx_vld, rx_overrun, rx_interrupt, rx_abort, rx_busy});
        end
        rst = 1'b0;
        wait_clks(5);
    endtask

    task automatic test_mode0;
        int bi, bv;
        rx_rdy = 1'b1;
        bi = int_cnt; bv = vld_cnt;
        cs_low(0, 0, 1, 6'd8);
        send_bits(32'hA5, 8, 1);
        cs_high();
        checks++;
        if (rx_rdata !== 32'h0000_00A5) begin
            errors++; $display("FAIL mode0_data: got %h expected 000000a5", rx_rdata);
        end
        checks++;
        if (int_cnt - bi !== 1) begin
            errors++; $display("FAIL mode0_int: got %0d pulses expected 1", int_cnt - bi);
        end
        checks++;
        if (vld_cnt - bv !== 1) begin
            errors++; $display("FAIL mode0_vld: got %0d cycles expected 1", vld_cnt - bv);
        end
        checks++;
        if (rx_overrun !== 1'b0) begin
            errors++; $display("FAIL mode0_ovr: got %b expected 0", rx_overrun);
        end
        checks++;
        if (vld_rise_t - sample_t !== 40) begin
            errors++; $display("FAIL mode0_latency: got %0t expected 40", vld_rise_t - sample_t);
        end
    endtask

    task automatic test_lsb_modes;
        int bi;
        bi = int_cnt;
        cs_low(1, 1, 0, 6'd32);
        send_bits(32'h1234_5678, 32, 0);
        cs_high();
        checks++;
        if (rx_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL mode3_lsb: got %h expected 12345678", rx_rdata);
        end
        checks++;
        if (int_cnt - bi !== 1) begin
            errors++; $display("FAIL mode3_int: got %0d pulses expected 1", int_cnt - bi);
        end
        bi = int_cnt;
        cs_low(0, 1, 0, 6'd40);
        send_bits(32'h1234_5678, 32, 0);
        cs_high();
        checks++;
        if (rx_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL mode1_lsb_clamp: got %h expected 12345678", rx_rdata);
        end
        checks++;
        if (int_cnt - bi !== 1) begin
            errors++; $display("FAIL mode1_int: got %0d pulses expected 1", int_cnt - bi);
        end
    endtask

    task automatic test_overrun;
        int bi;
        rx_rdy = 1'b0;
        bi = int_cnt;
        cs_low(0, 0, 1, 6'd8);
        send_bits(32'h11, 8, 1);
        send_bits(32'h22, 8, 1);
        send_bits(32'h33, 8, 1);
        cs_high();
        checks++;
        if (rx_rdata !== 32'h11) begin
            errors++; $display("FAIL ovr_data: got %h expected 00000011", rx_rdata);
        end
        checks++;
        if (rx_vld !== 1'b1) begin
            errors++; $display("FAIL ovr_vld: got %b expected 1", rx_vld);
        end
        checks++;
        if (int_cnt - bi !== 1) begin
            errors++; $display("FAIL ovr_int: got %0d pulses expected 1", int_cnt - bi);
        end
        checks++;
        if (rx_overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_flag: got %b expected 1", rx_overrun);
        end
        overrun_clr = 1'b1;
        wait_clks(1);
        overrun_clr = 1'b0;
        wait_clks(1);
        checks++;
        if (rx_overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_clear: got %b expected 0", rx_overrun);
        end
        rx_rdy = 1'b1;
        wait_clks(2);
        checks++;
        if (rx_vld !== 1'b0) begin
            errors++; $display("FAIL accept_vld: got %b expected 0", rx_vld);
        end
        checks++;
        if (rx_rdata !== 32'h11) begin
            errors++; $display("FAIL accept_hold: got %h expected 00000011", rx_rdata);
        end
    endtask

    task automatic test_len_capture;
        int bi;
        bi = int_cnt;
        cs_low(0, 0, 1, 6'd0);
        length = 6'd4;
        send_bits(32'hDEAD_BEEF >> 1, 31, 1);
        wait_clks(8);
        checks++;
        if (int_cnt - bi !== 0) begin
            errors++; $display("FAIL len_early: got %0d pulses expected 0", int_cnt - bi);
        end
        send_bits(32'h1, 1, 1);
        wait_clks(8);
        checks++;
        if (rx_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL len_data: got %h expected deadbeef", rx_rdata);
        end
        checks++;
        if (int_cnt - bi !== 1) begin
            errors++; $display("FAIL len_int: got %0d pulses expected 1", int_cnt - bi);
        end
        cs_high();
    endtask

    task automatic test_len1;
        int bi;
        bi = int_cnt;
        cs_low(1, 0, 1, 6'd1);
        send_bits(32'h5, 3, 1);
        cs_high();
        checks++;
        if (int_cnt - bi !== 3) begin
            errors++; $display("FAIL len1_int: got %0d pulses expected 3", int_cnt - bi);
        end
        checks++;
        if (rx_rdata !== 32'h1) begin
            errors++; $display("FAIL len1_data: got %h expected 00000001", rx_rdata);
        end
    endtask

    task automatic test_abort;
        int bi, ba, bv;
        bi = int_cnt; ba = abort_cnt; bv = vld_cnt;
        cs_low(0, 0, 1, 6'd8);
        send_bits(32'h1B, 5, 1);
        cs_high();
        checks++;
        if (abort_cnt - ba !== 1) begin
            errors++; $display("FAIL abort_pulse: got %0d pulses expected 1", abort_cnt - ba);
        end
        checks++;
        if ((int_cnt - bi !== 0) || (vld_cnt - bv !== 0)) begin
            errors++; $display("FAIL abort_novld: got int %0d vld %0d expected 0 0", int_cnt - bi, vld_cnt - bv);
        end
        cs_low(0, 0, 1, 6'd8);
        send_bits(32'h3C, 8, 1);
        cs_high();
        checks++;
        if (rx_rdata !== 32'h3C) begin
            errors++; $display("FAIL abort_next: got %h expected 0000003c", rx_rdata);
        end
        checks++;
        if (abort_cnt - ba !== 1) begin
            errors++; $display("FAIL abort_full: got %0d pulses expected 1", abort_cnt - ba);
        end
        checks++;
        if (int_cnt - bi !== 1) begin
            errors++; $display("FAIL abort_next_int: got %0d pulses expected 1", int_cnt - bi);
        end
    endtask

    task automatic test_reset_midframe;
        cs_low(0, 0, 1, 6'd8);
        send_bits(32'h5, 3, 1);
        wait_clks(2);
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++; $display("FAIL mid_busy: got %b expected 1", rx_busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rx_rdata, rx_vld, rx_overrun, rx_interrupt, rx_abort, rx_busy} !== 37'd0) begin
            errors++;
            $display("FAIL mid_reset: got %h expected 0",
                     {rx_rdata, rx_vld, rx_overrun, rx_interrupt, rx_abort, rx_busy});
        end
        wait_clks(2);
        spi_cs_n = 1'b1; spi_bus_clk = 1'b0;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(6);
        cs_low(0, 0, 1, 6'd8);
        send_bits(32'hFF, 8, 1);
        cs_high();
        checks++;
        if (rx_rdata !== 32'h0000_00FF) begin
            errors++; $display("FAIL post_reset: got %h expected 000000ff", rx_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_lsb_modes();
        test_overrun();
        test_len_capture();
        test_len1();
        test_abort();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
